fft_bitrev_reorder: RTL

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_bitrev_reorder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong two-bank buffer that re-emits each FFT frame in bit-reversed index order
module fft_bitrev_reorder #(
  parameter int float_len       = 32,
  parameter int bram_addr_len   = 13,
  parameter bit test_stall_read = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*float_len-1:0]   data_in,
  input  logic                     data_in_valid,
  output logic [2*float_len-1:0]   data_out,
  output logic                     data_out_valid,
  output logic                     frame_start,
  output logic                     overflow
);
  localparam int dw    = 2 * float_len;
  localparam int aw    = bram_addr_len;
  localparam int depth = 1 << aw;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;

  bank_t           bank_q [2];
  bank_t           bank_d [2];
  logic            wsel_q, wsel_d;
  logic [aw-1:0]   wcnt_q, wcnt_d;
  logic            rsel_q, rsel_d;
  logic [aw-1:0]   rcnt_q, rcnt_d;
  logic            ract_q, ract_d;
  logic            overflow_q, overflow_d;
  logic            re_q, re_d;
  logic [aw-1:0]   raddr_q, raddr_d;
  logic            rbank_q, rbank_d;
  logic            rfirst_q, rfirst_d;
  logic            rv_q, rv_d;
  logic            rf_q, rf_d;
  logic            rb_q, rb_d;
  logic [dw-1:0]   dout_q, dout_d;
  logic            dv_q, dv_d;
  logic            fs_q, fs_d;
  logic            wr_ok, drop, issue, last, we0, we1;
  logic [dw-1:0]   mem0 [depth];
  logic [dw-1:0]   mem1 [depth];
  logic [dw-1:0]   rd0_q, rd1_q;

  function automatic logic [aw-1:0] bitrev(input logic [aw-1:0] a);
    for (int i = 0; i < aw; i++) bitrev[i] = a[aw-1-i];
  endfunction

  // Bank state register; contents of the banks themselves are never reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '{default: EMPTY};
    else     bank_q <= bank_d;
  end

  // Bank state transitions: the write side owns EMPTY/FILLING banks, the read side owns FULL/DRAINING ones, so they never touch the same bank
  always_comb begin
    bank_d = bank_q;
    if (wr_ok) bank_d[wsel_q] = (&wcnt_q) ? FULL : FILLING;
    if (issue) bank_d[rsel_q] = last ? EMPTY : DRAINING;
  end

  // Per-cycle control decoded from bank state: accept/drop a word, issue a read address, write enables
  always_comb begin
    wr_ok = data_in_valid && (bank_q[wsel_q] == EMPTY || bank_q[wsel_q] == FILLING);
    drop  = data_in_valid && !wr_ok;
    issue = ract_q || (!test_stall_read && bank_q[rsel_q] == FULL);
    last  = issue && (&rcnt_q);
    we0   = wr_ok && !wsel_q;
    we1   = wr_ok && wsel_q;
  end

  // Counters, pointers and the three-stage read pipeline (address, memory, output register)
  always_comb begin
    wsel_d     = wsel_q ^ (wr_ok && (&wcnt_q));
    wcnt_d     = wr_ok ? wcnt_q + 1'b1 : wcnt_q;
    rsel_d     = rsel_q ^ last;
    rcnt_d     = issue ? rcnt_q + 1'b1 : rcnt_q;
    ract_d     = issue && !last;
    overflow_d = overflow_q || drop;
    re_d       = issue;
    raddr_d    = issue ? bitrev(rcnt_q) : raddr_q;
    rbank_d    = issue ? rsel_q : rbank_q;
    rfirst_d   = issue && (rcnt_q == '0);
    rv_d       = re_q;
    rf_d       = re_q && rfirst_q;
    rb_d       = rbank_q;
    dv_d       = rv_q;
    fs_d       = rf_q;
    dout_d     = rv_q ? (rb_q ? rd1_q : rd0_q) : '0;
  end

  // Control and output registers, all cleared asynchronously so a discarded frame cannot leak out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel_q     <= 1'b0;
      wcnt_q     <= '0;
      rsel_q     <= 1'b0;
      rcnt_q     <= '0;
      ract_q     <= 1'b0;
      overflow_q <= 1'b0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      rbank_q    <= 1'b0;
      rfirst_q   <= 1'b0;
      rv_q       <= 1'b0;
      rf_q       <= 1'b0;
      rb_q       <= 1'b0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      wsel_q     <= wsel_d;
      wcnt_q     <= wcnt_d;
      rsel_q     <= rsel_d;
      rcnt_q     <= rcnt_d;
      ract_q     <= ract_d;
      overflow_q <= overflow_d;
      re_q       <= re_d;
      raddr_q    <= raddr_d;
      rbank_q    <= rbank_d;
      rfirst_q   <= rfirst_d;
      rv_q       <= rv_d;
      rf_q       <= rf_d;
      rb_q       <= rb_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
    end
  end

  // Bank 0 RAM: one write port, one synchronous read port
  always_ff @(posedge clk) begin
    if (we0) mem0[wcnt_q] <= data_in;
    rd0_q <= mem0[raddr_q];
  end

  // Bank 1 RAM: one write port, one synchronous read port
  always_ff @(posedge clk) begin
    if (we1) mem1[wcnt_q] <= data_in;
    rd1_q <= mem1[raddr_q];
  end

  assign data_out       = dout_q;
  assign data_out_valid = dv_q;
  assign frame_start    = fs_q;
  assign overflow       = overflow_q;
endmodule
